// File: rtl/reg_file_pkg.sv
// Shared codes for the general register file and the register-pair sequencer:
// register selects, pair and op codes, and the sequencer FSM state encoding.
package reg_file_pkg;

    typedef logic [2:0] reg_sel_t;

    localparam reg_sel_t REG_B = 3'b000;
    localparam reg_sel_t REG_C = 3'b001;
    localparam reg_sel_t REG_D = 3'b010;
    localparam reg_sel_t REG_E = 3'b011;
    localparam reg_sel_t REG_H = 3'b100;
    localparam reg_sel_t REG_L = 3'b101;
    localparam reg_sel_t REG_A = 3'b111;

    localparam logic [1:0] PAIR_BC = 2'b00;
    localparam logic [1:0] PAIR_DE = 2'b01;
    localparam logic [1:0] PAIR_HL = 2'b10;
    localparam logic [1:0] PAIR_AF = 2'b11;

    localparam logic [1:0] OP_READ16 = 2'b00;
    localparam logic [1:0] OP_LOAD16 = 2'b01;
    localparam logic [1:0] OP_INC16  = 2'b10;
    localparam logic [1:0] OP_DEC16  = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD_LO = 3'd1;
    localparam logic [2:0] ST_RD_HI = 3'd2;
    localparam logic [2:0] ST_WR_LO = 3'd3;
    localparam logic [2:0] ST_WR_HI = 3'd4;
    localparam logic [2:0] ST_RESP  = 3'd5;

endpackage

// File: rtl/reg_pair_sequencer_pair_decode.sv
// Maps a register-pair code onto its low/high byte register selects.
// AF is not a sequencer pair and decodes as invalid with zero selects.
module pair_decode
    import reg_file_pkg::*;
(
    input  logic [1:0] pair,
    output reg_sel_t   lo_sel,
    output reg_sel_t   hi_sel,
    output logic       pair_ok
);

    always_comb begin
        lo_sel  = REG_B;
        hi_sel  = REG_B;
        pair_ok = 1'b1;
        case (pair)
            PAIR_BC: begin lo_sel = REG_C; hi_sel = REG_B; end
            PAIR_DE: begin lo_sel = REG_E; hi_sel = REG_D; end
            PAIR_HL: begin lo_sel = REG_L; hi_sel = REG_H; end
            default: pair_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/reg_pair_sequencer.sv
// 16-bit BC/DE/HL read/load/inc/dec sequenced over the 8-bit register file.
// Optional rsp_zero/rsp_carry outputs are built when REG_PAIR_SEQ_FLAGS_EN is defined.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// RD_LO  | reading low byte of the pair into lo
// RD_HI  | reading high byte, forming result
// WR_LO  | writing result[7:0] to low register
// WR_HI  | writing result[15:8] to high register
// RESP   | presenting response until rsp_ready
module reg_pair_sequencer
    import reg_file_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit ERR_ON_AF = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [1:0]            cmd_pair,
    input  logic [2*DATA_W-1:0]   cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [2*DATA_W-1:0]   rsp_data,
    output logic                  rsp_err,
`ifdef REG_PAIR_SEQ_FLAGS_EN
    output logic                  rsp_zero,
    output logic                  rsp_carry,
`endif
    output logic [2:0]            rf_wr_sel,
    output logic [2:0]            rf_rd_sel,
    output logic                  rf_wr_en,
    output logic                  rf_rd_en,
    output logic [DATA_W-1:0]     rf_wdata,
    input  logic [DATA_W-1:0]     rf_rdata
);

    logic [2:0]          state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [1:0]          pair_q, pair_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic [2*DATA_W-1:0] rd_word;
`ifdef REG_PAIR_SEQ_FLAGS_EN
    logic                carry_q, carry_d;
`endif

    reg_sel_t lo_sel, hi_sel;
    logic     pair_ok;

    pair_decode u_pair_decode (
        .pair    (pair_q),
        .lo_sel  (lo_sel),
        .hi_sel  (hi_sel),
        .pair_ok (pair_ok)
    );

    assign rd_word = {rf_rdata, lo_q};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        pair_d   = pair_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        result_d = result_q;
`ifdef REG_PAIR_SEQ_FLAGS_EN
        carry_d  = carry_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    pair_d = cmd_pair;
`ifdef REG_PAIR_SEQ_FLAGS_EN
                    carry_d = 1'b0;
`endif
                    if (cmd_pair == PAIR_AF) begin
                        result_d = '0;
                        state_d  = ST_RESP;
                    end else if (cmd_op == OP_LOAD16) begin
                        result_d = cmd_wdata;
                        state_d  = ST_WR_LO;
                    end else begin
                        state_d = ST_RD_LO;
                    end
                end
            end
            ST_RD_LO: begin
                lo_d    = rf_rdata;
                state_d = ST_RD_HI;
            end
            ST_RD_HI: begin
                hi_d = rf_rdata;
                case (op_q)
                    OP_INC16: begin
                        result_d = rd_word + 1'b1;
`ifdef REG_PAIR_SEQ_FLAGS_EN
                        carry_d  = &rd_word;
`endif
                    end
                    OP_DEC16: begin
                        result_d = rd_word - 1'b1;
`ifdef REG_PAIR_SEQ_FLAGS_EN
                        carry_d  = ~|rd_word;
`endif
                    end
                    default: result_d = rd_word;
                endcase
                state_d = (op_q == OP_READ16) ? ST_RESP : ST_WR_LO;
            end
            ST_WR_LO: state_d = ST_WR_HI;
            ST_WR_HI: state_d = ST_RESP;
            ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_READ16;
            pair_q   <= PAIR_BC;
            lo_q     <= '0;
            hi_q     <= '0;
            result_q <= '0;
`ifdef REG_PAIR_SEQ_FLAGS_EN
            carry_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            pair_q   <= pair_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            result_q <= result_d;
`ifdef REG_PAIR_SEQ_FLAGS_EN
            carry_q  <= carry_d;
`endif
        end
    end

    // Enables are masked by rst so a reset in WR_HI cannot land the high byte.
    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_err   = 1'b0;
        rf_wr_sel = REG_B;
        rf_rd_sel = REG_B;
        rf_wr_en  = 1'b0;
        rf_rd_en  = 1'b0;
        rf_wdata  = '0;
        case (state_q)
            ST_RD_LO: begin
                rf_rd_en  = ~rst;
                rf_rd_sel = lo_sel;
            end
            ST_RD_HI: begin
                rf_rd_en  = ~rst;
                rf_rd_sel = hi_sel;
            end
            ST_WR_LO: begin
                rf_wr_en  = ~rst;
                rf_wr_sel = lo_sel;
                rf_wdata  = result_q[DATA_W-1:0];
            end
            ST_WR_HI: begin
                rf_wr_en  = ~rst;
                rf_wr_sel = hi_sel;
                rf_wdata  = result_q[2*DATA_W-1:DATA_W];
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (pair_ok) begin
                    rsp_data = (op_q == OP_READ16) ? {hi_q, lo_q} : result_q;
                end else begin
                    rsp_err = ERR_ON_AF;
                end
            end
            default: ;
        endcase
    end

`ifdef REG_PAIR_SEQ_FLAGS_EN
    always_comb begin
        rsp_zero  = (state_q == ST_RESP) && pair_ok &&
                    ((op_q == OP_INC16) || (op_q == OP_DEC16)) && (result_q == '0);
        rsp_carry = (state_q == ST_RESP) && carry_q;
    end
`endif

endmodule

// File: doc/reg_pair_sequencer.md
Name: reg_pair_sequencer

Overview:
Sequences 16-bit register-pair operations (BC, DE, HL) over the 8-bit single-read/single-write general register file. Requesters issue one command at a time through a valid/ready handshake. The block drives the file's wr_sel/rd_sel/wr_en/rd_en/data_in and captures its data_out. It returns a 16-bit result through a second valid/ready handshake. It sits between the CPU control unit and the register file and is the only writer of the file while busy.

Parameters:
DATA_W, 8, register width; only 8 is supported; pair width is 2*DATA_W.
ERR_ON_AF, 1, pair code 2'b11: 1 = respond with rsp_err=1 and touch nothing; 0 = respond with rsp_err=0, rsp_data=0, no file access.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command (IDLE only)
cmd_op  in  2  00 READ16, 01 LOAD16, 10 INC16, 11 DEC16
cmd_pair  in  2  00 BC, 01 DE, 10 HL, 11 AF (not supported)
cmd_wdata  in  16  LOAD16 value, {hi,lo}
rsp_valid  out  1  response present
rsp_ready  in  1  requester takes response
rsp_data  out  16  READ16 value, or new pair value for LOAD16/INC16/DEC16
rsp_err  out  1  unsupported pair
rf_wr_sel  out  3  to register file wr_sel
rf_rd_sel  out  3  to register file rd_sel
rf_wr_en  out  1  to register file wr_en
rf_rd_en  out  1  to register file rd_en
rf_wdata  out  8  to register file data_in
rf_rdata  in  8  from register file data_out (combinational read)

Behaviour:
- Register codes: B=000, C=001, D=010, E=011, H=100, L=101, A=111. Low/high byte per pair: BC: C/B; DE: E/D; HL: L/H.
- FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, RESP.
- Reset: state=IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, rf_wr_en=0, rf_rd_en=0, rf_wr_sel=rf_rd_sel=000, rf_wdata=0, internal lo/hi/result registers=0.
- Accept: cmd_valid & cmd_ready at a clk edge latches op, pair and wdata. cmd_ready=1 only in IDLE. No command is accepted while rsp_valid=1.
- Transitions from IDLE on accept:
  - pair=11 -> RESP.
  - READ16, INC16, DEC16 -> RD_LO.
  - LOAD16 -> WR_LO.
- RD_LO: rf_rd_en=1, rf_rd_sel=low code; latch rf_rdata into lo at edge; -> RD_HI.
- RD_HI: rf_rd_en=1, rf_rd_sel=high code; latch hi; result <= {rf_rdata,lo} ±1 (mod 2^16; INC/DEC), or {rf_rdata,lo} for READ16. -> RESP for READ16, else -> WR_LO.
- LOAD16: result <= cmd_wdata at accept.
- WR_LO: rf_wr_en=1, rf_wr_sel=low code, rf_wdata=result[7:0]; -> WR_HI.
- WR_HI: rf_wr_en=1, rf_wr_sel=high code, rf_wdata=result[15:8]; -> RESP.
- RESP: rsp_valid=1, rsp_data=result, rsp_err as defined by ERR_ON_AF. Outputs hold stable until rsp_valid & rsp_ready, then -> IDLE.
- Latency, accept edge to first rsp_valid cycle: READ16 3, LOAD16 3, INC16/DEC16 5, invalid pair 1.
- Wrap: INC16 of 0xFFFF -> 0x0000; DEC16 of 0x0000 -> 0xFFFF.
- rf_rd_en=0 and rf_wr_en=0 in every state not listed above. rf_rd_en and rf_wr_en are never both 1.
- Outputs are decoded from registered state/fields, with no combinational path from cmd_* to rf_*.
- Reset mid-operation: state returns to IDLE on the reset edge and rf_wr_en is 0 the next cycle. Reset during WR_HI leaves a completed low-byte write in the file; this is accepted.

Optional Feature:
REG_PAIR_SEQ_FLAGS_EN
- Defined: adds outputs rsp_zero (result==0) and rsp_carry (INC16 wrapped 0xFFFF->0 or DEC16 wrapped 0->0xFFFF). Both are valid with rsp_valid and are 0 for READ16, LOAD16 and error responses.
- Undefined: ports absent, no flag logic.

Decomposition:
- Shared package reg_file_pkg holds:
  - register select codes REG_A..REG_L;
  - pair codes PAIR_BC/DE/HL/AF;
  - op codes OP_READ16/LOAD16/INC16/DEC16;
  - FSM state encoding.
- One natural sub-module: pair_decode (pair code -> low/high 3-bit select, valid flag), purely combinational. Everything else stays in the top module.

Test Plan:
- LOAD16 HL=0x1234, then READ16 HL -> write cycles L=0x34 then H=0x12. READ rsp_data=0x1234, rsp_valid on 3rd cycle after accept.
- LOAD16 DE=0xFFFF, INC16 DE -> rsp_data=0x0000, file D=0x00 E=0x00, flags build rsp_carry=1 rsp_zero=1. DEC16 DE -> 0xFFFF, carry=1.
- INC16 BC from 0x00FF -> 0x0100, writes C=0x00 then B=0x01, latency 5. A and HL unchanged.
- cmd pair=11 with ERR_ON_AF=1 -> rsp_err=1, rsp_valid next cycle, rf_wr_en never asserted. With ERR_ON_AF=0 -> rsp_err=0, rsp_data=0.
- Hold rsp_ready=0 for 4 cycles with cmd_valid=1 -> rsp fields stable, cmd_ready=0 throughout. Second command accepted only after the response handshake.
- Assert rst in WR_HI of LOAD16 BC=0xABCD (prior BC=0x0000) -> next cycle IDLE, cmd_ready=1, rsp_valid=0. File C=0xCD, B=0x00.
